// File: rtl/cache_ctrl_pkg.sv
// Shared types and select encodings for the L1 cache control path.
package cache_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    COMPARE,
    WB,
    FILL
  } state_e;

  localparam logic [1:0] WEN_NONE = 2'b00;
  localparam logic [1:0] WEN_LINE = 2'b01;
  localparam logic [1:0] WEN_BYTE = 2'b10;

  localparam logic DIN_PMEM = 1'b0;
  localparam logic DIN_CPU  = 1'b1;

  // lru_out = 1 names way1 as the victim, so its dirty bit decides write-back.
  function automatic logic victim_dirty(input logic lru_out,
                                        input logic dirty1,
                                        input logic dirty2);
    return lru_out ? dirty1 : dirty2;
  endfunction

endpackage

// File: rtl/cache_control_sat_counter.sv
// Saturating up-counter used for the cache hit/miss statistics.
module sat_counter #(
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inc,
  output logic [CNT_WIDTH-1:0] count
);

  logic [CNT_WIDTH-1:0] count_q;
  logic [CNT_WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/cache_control.sv
// Control FSM for the 2-way write-back L1 cache: handshakes, datapath selects,
// array loads and hit/miss statistics.
module cache_control
  import cache_ctrl_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mem_read,
  input  logic                 mem_write,
  input  logic                 hit1,
  input  logic                 hit2,
  input  logic                 dirty1,
  input  logic                 dirty2,
  input  logic                 lru_out,
  input  logic                 pmem_resp,
  output logic                 mem_resp,
  output logic                 pmem_read,
  output logic                 pmem_write,
  output logic                 lru,
  output logic                 data_way_sel,
  output logic                 pmem_address_sel,
  output logic                 data1_datain_sel,
  output logic                 data2_datain_sel,
  output logic [1:0]           data1_write_en_sel,
  output logic [1:0]           data2_write_en_sel,
  output logic                 tag1_load,
  output logic                 tag2_load,
  output logic                 valid1_load,
  output logic                 valid2_load,
  output logic                 dirty1_load,
  output logic                 dirty2_load,
  output logic                 dirty_in,
  output logic                 lru_load,
  output logic                 lru_in,
  output logic [CNT_WIDTH-1:0] hit_count,
  output logic [CNT_WIDTH-1:0] miss_count
);

  state_e state_q, state_d;
  logic   refill_q, refill_d;
  logic   hit_inc;
  logic   miss_inc;

  assign lru = lru_out;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      refill_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      refill_q <= refill_d;
    end
  end

  always_comb begin
    state_d            = state_q;
    refill_d           = refill_q;
    hit_inc            = 1'b0;
    miss_inc           = 1'b0;
    mem_resp           = 1'b0;
    pmem_read          = 1'b0;
    pmem_write         = 1'b0;
    data_way_sel       = 1'b0;
    pmem_address_sel   = 1'b0;
    data1_datain_sel   = DIN_PMEM;
    data2_datain_sel   = DIN_PMEM;
    data1_write_en_sel = WEN_NONE;
    data2_write_en_sel = WEN_NONE;
    tag1_load          = 1'b0;
    tag2_load          = 1'b0;
    valid1_load        = 1'b0;
    valid2_load        = 1'b0;
    dirty1_load        = 1'b0;
    dirty2_load        = 1'b0;
    dirty_in           = 1'b0;
    lru_load           = 1'b0;
    lru_in             = 1'b0;

    case (state_q)
      IDLE: begin
        if (mem_read || mem_write) begin
          state_d  = COMPARE;
          refill_d = 1'b0;
        end
      end

      COMPARE: begin
        if (hit1 || hit2) begin
          mem_resp     = 1'b1;
          state_d      = IDLE;
          data_way_sel = hit2 & ~hit1;
          lru_load     = 1'b1;
          lru_in       = ~hit1;
          // A hit on the re-compare after a refill is the same request, not a new hit.
          hit_inc      = ~refill_q;
          if (mem_write) begin
            dirty_in = 1'b1;
            if (hit1) begin
              data1_datain_sel   = DIN_CPU;
              data1_write_en_sel = WEN_BYTE;
              dirty1_load        = 1'b1;
            end else begin
              data2_datain_sel   = DIN_CPU;
              data2_write_en_sel = WEN_BYTE;
              dirty2_load        = 1'b1;
            end
          end
        end else begin
          miss_inc = 1'b1;
          state_d  = victim_dirty(lru_out, dirty1, dirty2) ? WB : FILL;
        end
      end

      WB: begin
        pmem_write       = 1'b1;
        pmem_address_sel = 1'b1;
        data_way_sel     = ~lru_out;
        if (pmem_resp) begin
          state_d = FILL;
        end
      end

      FILL: begin
        pmem_read = 1'b1;
        if (pmem_resp) begin
          refill_d = 1'b1;
          state_d  = COMPARE;
          if (lru_out) begin
            data1_write_en_sel = WEN_LINE;
            tag1_load          = 1'b1;
            valid1_load        = 1'b1;
            dirty1_load        = 1'b1;
          end else begin
            data2_write_en_sel = WEN_LINE;
            tag2_load          = 1'b1;
            valid2_load        = 1'b1;
            dirty2_load        = 1'b1;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_hit_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (hit_inc),
    .count (hit_count)
  );

  sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_miss_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (miss_inc),
    .count (miss_count)
  );

endmodule

// File: tb/tb_cache_control.sv
// Randomized bench for cache_control driven from a small set/way cache model.
module tb_cache_control;

  logic clk = 1'b0;
  logic rst, mem_read, mem_write, hit1, hit2, dirty1, dirty2, lru_out, pmem_resp;
  logic mem_resp, pmem_read, pmem_write, lru, data_way_sel, pmem_address_sel;
  logic data1_datain_sel, data2_datain_sel;
  logic [1:0] data1_write_en_sel, data2_write_en_sel;
  logic tag1_load, tag2_load, valid1_load, valid2_load;
  logic dirty1_load, dirty2_load, dirty_in, lru_load, lru_in;
  logic [15:0] hit_count, miss_count;

  logic s_mem_resp, s_pmem_read, s_pmem_write, s_lru, s_dws, s_pas, s_d1s, s_d2s;
  logic [1:0] s_d1w, s_d2w;
  logic s_t1, s_t2, s_v1, s_v2, s_dl1, s_dl2, s_din, s_ll, s_li;
  logic [1:0] s_hit_count, s_miss_count;

  always #5 clk = ~clk;

  cache_control #(.CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .hit1(hit1), .hit2(hit2), .dirty1(dirty1), .dirty2(dirty2),
    .lru_out(lru_out), .pmem_resp(pmem_resp), .mem_resp(mem_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .lru(lru),
    .data_way_sel(data_way_sel), .pmem_address_sel(pmem_address_sel),
    .data1_datain_sel(data1_datain_sel), .data2_datain_sel(data2_datain_sel),
    .data1_write_en_sel(data1_write_en_sel), .data2_write_en_sel(data2_write_en_sel),
    .tag1_load(tag1_load), .tag2_load(tag2_load),
    .valid1_load(valid1_load), .valid2_load(valid2_load),
    .dirty1_load(dirty1_load), .dirty2_load(dirty2_load), .dirty_in(dirty_in),
    .lru_load(lru_load), .lru_in(lru_in),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  // Narrow-counter instance sharing the same stimulus, to exercise saturation.
  cache_control #(.CNT_WIDTH(2)) dut_sat (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .hit1(hit1), .hit2(hit2), .dirty1(dirty1), .dirty2(dirty2),
    .lru_out(lru_out), .pmem_resp(pmem_resp), .mem_resp(s_mem_resp),
    .pmem_read(s_pmem_read), .pmem_write(s_pmem_write), .lru(s_lru),
    .data_way_sel(s_dws), .pmem_address_sel(s_pas),
    .data1_datain_sel(s_d1s), .data2_datain_sel(s_d2s),
    .data1_write_en_sel(s_d1w), .data2_write_en_sel(s_d2w),
    .tag1_load(s_t1), .tag2_load(s_t2), .valid1_load(s_v1), .valid2_load(s_v2),
    .dirty1_load(s_dl1), .dirty2_load(s_dl2), .dirty_in(s_din),
    .lru_load(s_ll), .lru_in(s_li),
    .hit_count(s_hit_count), .miss_count(s_miss_count)
  );

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  // Cache model: per set, two ways of tag/valid/dirty plus the victim bit
  // (lrum = 1 means way1 is the next victim).
  bit [1:0] tagm [8][2];
  bit       valm [8][2];
  bit       dirm [8][2];
  bit       lrum [8];
  int unsigned hits_m = 0;
  int unsigned misses_m = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_lookup(input int s, input int t);
    hit1    = valm[s][0] && (tagm[s][0] == 2'(t));
    hit2    = valm[s][1] && (tagm[s][1] == 2'(t));
    dirty1  = valm[s][0] && dirm[s][0];
    dirty2  = valm[s][1] && dirm[s][1];
    lru_out = lrum[s];
  endtask

  task automatic chk_counters();
    chk("hit_count", 32'(hit_count), hits_m);
    chk("miss_count", 32'(miss_count), misses_m);
    chk("sat_hit_count", 32'(s_hit_count), (hits_m > 3) ? 3 : hits_m);
    chk("sat_miss_count", 32'(s_miss_count), (misses_m > 3) ? 3 : misses_m);
  endtask

  // Expected response in COMPARE when way w (0 = way1, 1 = way2) matches.
  task automatic chk_hit(input int w, input bit wr);
    chk("hit_mem_resp", 32'(mem_resp), 1);
    chk("hit_way_sel", 32'(data_way_sel), w);
    chk("hit_lru_load", 32'(lru_load), 1);
    chk("hit_lru_in", 32'(lru_in), w);
    chk("hit_pmem", 32'({pmem_read, pmem_write}), 0);
    chk("hit_d1_wen", 32'(data1_write_en_sel), (wr && w == 0) ? 2 : 0);
    chk("hit_d2_wen", 32'(data2_write_en_sel), (wr && w == 1) ? 2 : 0);
    chk("hit_d1_din", 32'(data1_datain_sel), (wr && w == 0) ? 1 : 0);
    chk("hit_d2_din", 32'(data2_datain_sel), (wr && w == 1) ? 1 : 0);
    chk("hit_dirty_ld", 32'({dirty1_load, dirty2_load}),
        wr ? ((w == 0) ? 2 : 1) : 0);
    chk("hit_dirty_in", 32'(dirty_in), wr);
    chk("hit_tag_ld", 32'({tag1_load, tag2_load, valid1_load, valid2_load}), 0);
  endtask

  task automatic model_hit(input int s, input int w, input bit wr);
    lrum[s] = (w == 1);
    if (wr) dirm[s][w] = 1'b1;
  endtask

  task automatic run_txn(input int s, input int t, input int op);
    bit wr;
    int w, vic, lat;
    bit vd;
    mem_read  = (op != 1);
    mem_write = (op != 0);
    wr = mem_write;
    drive_lookup(s, t);
    #1;
    chk("idle_resp", 32'({mem_resp, pmem_read, pmem_write, lru_load}), 0);
    step();
    #1;
    if (hit1 || hit2) begin
      w = hit1 ? 0 : 1;
      chk_hit(w, wr);
      model_hit(s, w, wr);
      hits_m++;
      step();
    end else begin
      chk("miss_resp", 32'({mem_resp, lru_load, pmem_read, pmem_write}), 0);
      misses_m++;
      vic = lrum[s] ? 0 : 1;
      vd  = valm[s][vic] && dirm[s][vic];
      step();
      if (vd) begin
        lat = $urandom_range(0, 3);
        for (int c = 0; c <= lat; c++) begin
          pmem_resp = (c == lat);
          #1;
          chk("wb_pmem", 32'({pmem_write, pmem_read}), 2);
          chk("wb_addr_sel", 32'(pmem_address_sel), 1);
          chk("wb_way_sel", 32'(data_way_sel), vic);
          chk("wb_quiet", 32'({mem_resp, tag1_load, tag2_load, lru_load}), 0);
          step();
        end
        pmem_resp = 1'b0;
      end
      lat = $urandom_range(0, 5);
      for (int c = 0; c <= lat; c++) begin
        pmem_resp = (c == lat);
        #1;
        chk("fill_pmem", 32'({pmem_write, pmem_read}), 1);
        chk("fill_addr_sel", 32'(pmem_address_sel), 0);
        chk("fill_resp", 32'(mem_resp), 0);
        chk("fill_d1_wen", 32'(data1_write_en_sel), (c == lat && vic == 0) ? 1 : 0);
        chk("fill_d2_wen", 32'(data2_write_en_sel), (c == lat && vic == 1) ? 1 : 0);
        chk("fill_loads1", 32'({tag1_load, valid1_load, dirty1_load}),
            (c == lat && vic == 0) ? 7 : 0);
        chk("fill_loads2", 32'({tag2_load, valid2_load, dirty2_load}),
            (c == lat && vic == 1) ? 7 : 0);
        if (c == lat) begin
          chk("fill_din", 32'({data1_datain_sel, data2_datain_sel, dirty_in}), 0);
        end
        step();
      end
      pmem_resp = 1'b0;
      tagm[s][vic] = 2'(t);
      valm[s][vic] = 1'b1;
      dirm[s][vic] = 1'b0;
      drive_lookup(s, t);
      #1;
      chk_hit(vic, wr);
      model_hit(s, vic, wr);
      step();
    end
    mem_read  = 1'b0;
    mem_write = 1'b0;
    hit1 = 1'b0;
    hit2 = 1'b0;
    #1;
    chk_counters();
  endtask

  initial begin
    rst = 1'b0;
    {mem_read, mem_write, hit1, hit2, dirty1, dirty2, lru_out, pmem_resp} = '0;
    repeat (3) step();
    chk("reset_outs", 32'({mem_resp, pmem_read, pmem_write, lru_load, data_way_sel,
                           tag1_load, tag2_load, dirty1_load, dirty2_load}), 0);
    chk_counters();
    rst = 1'b1;
    step();

    for (int i = 0; i < 60; i++) begin
      run_txn($urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 2));
      if ($urandom_range(0, 3) == 0) begin
        #1;
        chk("idle_gap", 32'({mem_resp, pmem_read, pmem_write, lru_load}), 0);
        step();
      end
    end

    // Both ways reporting a hit with read+write: way1 wins, write path taken.
    mem_read = 1'b1; mem_write = 1'b1; hit1 = 1'b1; hit2 = 1'b1;
    lru_out = 1'b1; dirty1 = 1'b0; dirty2 = 1'b0;
    step();
    #1;
    chk_hit(0, 1'b1);
    hits_m++;
    step();
    {mem_read, mem_write, hit1, hit2} = '0;
    #1;
    chk_counters();

    // Reset while writing back: pmem_write must drop and a late resp is ignored.
    mem_read = 1'b1; lru_out = 1'b1; dirty1 = 1'b1; dirty2 = 1'b0;
    step();
    step();
    #1;
    chk("pre_rst_wb", 32'(pmem_write), 1);
    rst = 1'b0;
    step();
    rst = 1'b1;
    mem_read = 1'b0;
    hits_m = 0;
    misses_m = 0;
    #1;
    chk("rst_wb_pmem", 32'({pmem_write, pmem_read, mem_resp}), 0);
    chk_counters();
    pmem_resp = 1'b1;
    step();
    pmem_resp = 1'b0;
    #1;
    chk("late_resp_ignored", 32'({pmem_write, pmem_read, mem_resp}), 0);
    step();

    for (int i = 0; i < 20; i++) begin
      run_txn($urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
